// File: rtl/tx_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tx_arbiter_pkg : shared comms constants, arbiter states, sat helper   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package tx_arbiter_pkg;

    localparam int CFG_BURST_DEFAULT = 4;
    localparam int BUSY_WAIT_DEFAULT = 4;
    localparam int COUNT_W           = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT_CFG  = 3'd1,
        READ_FIFO  = 3'd2,
        LATCH_FIFO = 3'd3,
        LOAD       = 3'd4,
        WAIT_BUSY  = 3'd5,
        WAIT_DONE  = 3'd6
    } tx_state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == {COUNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_sat_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tx_sat_counter : 16-bit counter that sticks at all-ones               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tx_sat_counter
    import tx_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tx_arbiter : arbitrates config replies and FIFO events onto a tx UART |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CFG_BURST = CFG_BURST_DEFAULT,
    parameter int BUSY_WAIT = BUSY_WAIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_req,
    input  logic [WIDTH-1:0]   cfg_data,
    output logic               cfg_ack,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_data,
    output logic               read_fifo_n,
    input  logic               tx_busy,
    output logic [WIDTH-1:0]   tx_data,
    output logic               ld_tx_data,
    output logic [COUNT_W-1:0] tx_cfg_count,
    output logic [COUNT_W-1:0] tx_fifo_count,
    output logic               tx_timeout
);

    localparam int STREAK_W = $clog2(CFG_BURST + 1);
    localparam int WAIT_W   = $clog2(BUSY_WAIT + 1);

    tx_state_e           state;
    tx_state_e           next_state;
    logic [STREAK_W-1:0] streak;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_expired;
    logic                fifo_starved;

    assign wait_expired = (wait_cnt == WAIT_W'(BUSY_WAIT - 1));
    assign fifo_starved = !fifo_empty && (streak == STREAK_W'(CFG_BURST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!tx_busy) begin
                    if (cfg_req && !fifo_starved) begin
                        next_state = GRANT_CFG;
                    end else if (!fifo_empty) begin
                        next_state = READ_FIFO;
                    end
                end
            end
            GRANT_CFG:  next_state = LOAD;
            READ_FIFO:  next_state = LATCH_FIFO;
            LATCH_FIFO: next_state = LOAD;
            LOAD:       next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    next_state = WAIT_DONE;
                end else if (wait_expired) begin
                    next_state = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    next_state = IDLE;
                end
            end
            default:    next_state = IDLE;
        endcase
    end

    // Strobes are registered from next_state so each one lines up with its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ack     <= 1'b0;
            read_fifo_n <= 1'b1;
            ld_tx_data  <= 1'b0;
            tx_data     <= '0;
            streak      <= '0;
            wait_cnt    <= '0;
            tx_timeout  <= 1'b0;
        end else begin
            cfg_ack     <= (next_state == GRANT_CFG);
            read_fifo_n <= (next_state != READ_FIFO);
            ld_tx_data  <= (next_state == LOAD);

            if (next_state == GRANT_CFG) begin
                tx_data <= cfg_data;
            end else if (state == LATCH_FIFO) begin
                tx_data <= fifo_data;
            end

            if ((state == IDLE && fifo_empty) || state == READ_FIFO) begin
                streak <= '0;
            end else if (state == GRANT_CFG && streak != STREAK_W'(CFG_BURST)) begin
                streak <= streak + 1'b1;
            end

            wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 1'b1 : '0;

            if (state == WAIT_BUSY && !tx_busy && wait_expired) begin
                tx_timeout <= 1'b1;
            end
        end
    end

    tx_sat_counter u_cfg_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (state == GRANT_CFG),
        .count   (tx_cfg_count)
    );

    tx_sat_counter u_fifo_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (state == LATCH_FIFO),
        .count   (tx_fifo_count)
    );

endmodule
`default_nettype wire
